// File: rtl/tq_pp_buf_2p_pkg.sv
// rtl/tq_pp_buf_2p_pkg.sv - shared types and TQ-instance defaults for the ping-pong buffer
//
// Contents:
//   bank_st_e   - bank ownership encoding (FREE: producer may fill, FULL: consumer may drain)
//   TQ_DW/AW/DEPTH - default geometry used by the TQ stage instance

package tq_pp_buf_2p_pkg;

   typedef enum logic {
      BANK_FREE = 1'b0,
      BANK_FULL = 1'b1
   } bank_st_e;

   localparam int TQ_DW    = 128;
   localparam int TQ_AW    = 5;
   localparam int TQ_DEPTH = 24;

endpackage

// File: rtl/tq_pp_buf_2p_if.sv
// rtl/tq_pp_buf_2p_if.sv - producer/consumer handshake bundle for the ping-pong buffer
//
// Signals:
//   wr_en/wr_addr/wr_data/wr_done  producer side, into the buffer
//   wr_ready                       current write bank is FREE
//   rd_en/rd_addr/rd_done          consumer side, into the buffer
//   rd_data/rd_valid               registered read data, 1-cycle latency
//   rd_avail                       current read bank is FULL
//   full_cnt                       number of FULL banks (0..2)
//   err                            sticky protocol-violation flag
// Modports:
//   master - the producer/consumer pair driving the buffer
//   slave  - the buffer itself

interface tq_pp_buf_2p_if
   import tq_pp_buf_2p_pkg::*;
#(
   parameter int DW = TQ_DW,
   parameter int AW = TQ_AW
);
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_done;
   logic          wr_ready;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_avail;
   logic          rd_done;
   logic [1:0]    full_cnt;
   logic          err;

   modport master (
      output wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
      input  wr_ready, rd_data, rd_valid, rd_avail, full_cnt, err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
      output wr_ready, rd_data, rd_valid, rd_avail, full_cnt, err
   );
endinterface

// File: rtl/tq_pp_buf_2p_ram.sv
// rtl/tq_pp_buf_2p_ram.sv - generic 1R1W synchronous array with registered read port
//
// Ports:
//   clk, rst        clock, async active-high reset (clears the read register only)
//   we/waddr/wdata  write port
//   re/raddr        read port; q updates on the edge after re, holds otherwise
//   q               registered read data
// The array itself is never reset. Read-during-write ordering is left
// undefined: the ping-pong control guarantees the two ports never hit the
// same bank in the same cycle.

module tq_ram_2p_param #(
   parameter int DW = 128,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] q
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (re) begin
         q <= mem[raddr];
      end
   end

endmodule

// File: rtl/tq_pp_buf_2p.sv
// rtl/tq_pp_buf_2p.sv - ping-pong two-port buffer between TQ producer and its consumer
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  tq_pp_buf_2p_if.slave handshake bundle (see interface for signals)
// Two banks of DEPTH words; the producer owns bank wbank while it is FREE,
// the consumer owns bank rbank while it is FULL. Ownership only moves on
// accepted wr_done/rd_done, so reads and writes never alias a bank.

module tq_pp_buf_2p
   import tq_pp_buf_2p_pkg::*;
#(
   parameter int DW    = TQ_DW,
   parameter int AW    = TQ_AW,
   parameter int DEPTH = TQ_DEPTH
) (
   input logic            clk,
   input logic            rst,
   tq_pp_buf_2p_if.slave  bus
);

   localparam logic [31:0] DEPTH_U = 32'(DEPTH);

   logic [1:0] bank_st;
   logic       wbank;
   logic       rbank;

   logic wr_ready_c;
   logic rd_avail_c;
   logic wr_addr_ok;
   logic rd_addr_ok;
   logic wr_ok;
   logic wd_ok;
   logic rd_ok;
   logic rdn_ok;
   logic viol;

   // Outputs derive only from registered state, so a bank released by
   // rd_done shows up on wr_ready one cycle later, never combinationally.
   assign wr_ready_c = (bank_st[wbank] == BANK_FREE);
   assign rd_avail_c = (bank_st[rbank] == BANK_FULL);

   assign wr_addr_ok = (32'(bus.wr_addr) < DEPTH_U);
   assign rd_addr_ok = (32'(bus.rd_addr) < DEPTH_U);

   assign wr_ok  = bus.wr_en   && wr_ready_c && wr_addr_ok;
   assign wd_ok  = bus.wr_done && wr_ready_c;
   assign rd_ok  = bus.rd_en   && rd_avail_c && rd_addr_ok;
   assign rdn_ok = bus.rd_done && rd_avail_c;

   assign viol = ((bus.wr_en || bus.wr_done) && !wr_ready_c) ||
                 ((bus.rd_en || bus.rd_done) && !rd_avail_c) ||
                 (bus.wr_en && !wr_addr_ok) ||
                 (bus.rd_en && !rd_addr_ok);

   // wd_ok targets a FREE bank and rdn_ok a FULL one, so the two updates
   // below never land on the same bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_st      <= {BANK_FREE, BANK_FREE};
         wbank        <= 1'b0;
         rbank        <= 1'b0;
         bus.rd_valid <= 1'b0;
         bus.err      <= 1'b0;
      end else begin
         if (wd_ok) begin
            bank_st[wbank] <= BANK_FULL;
            wbank          <= ~wbank;
         end
         if (rdn_ok) begin
            bank_st[rbank] <= BANK_FREE;
            rbank          <= ~rbank;
         end
         bus.rd_valid <= rd_ok;
         if (viol) begin
            bus.err <= 1'b1;
         end
      end
   end

   assign bus.wr_ready = wr_ready_c;
   assign bus.rd_avail = rd_avail_c;
   assign bus.full_cnt = {1'b0, bank_st[0]} + {1'b0, bank_st[1]};

   // Physical address is {bank, word}; the old bank is used for a write or
   // read that coincides with its done strobe.
   tq_ram_2p_param #(
      .DW (DW),
      .AW (AW + 1)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_ok),
      .waddr ({wbank, bus.wr_addr}),
      .wdata (bus.wr_data),
      .re    (rd_ok),
      .raddr ({rbank, bus.rd_addr}),
      .q     (bus.rd_data)
   );

endmodule

// File: tb/tb_tq_pp_buf_2p.sv
// tb/tb_tq_pp_buf_2p.sv - directed self-checking bench for tq_pp_buf_2p

module tb_tq_pp_buf_2p;

   localparam int DW    = 128;
   localparam int AW    = 5;
   localparam int DEPTH = 24;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   tq_pp_buf_2p_if #(.DW(DW), .AW(AW)) bus ();

   tq_pp_buf_2p #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.wr_done = 1'b0;
      bus.rd_en   = 1'b0;
      bus.rd_addr = '0;
      bus.rd_done = 1'b0;
   endtask

   task automatic wr_word(input int a, input int d, input logic done);
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(a);
      bus.wr_data = DW'(d);
      bus.wr_done = done;
      tick();
      idle();
   endtask

   task automatic rd_word(input int a, input logic done);
      bus.rd_en   = 1'b1;
      bus.rd_addr = AW'(a);
      bus.rd_done = done;
      tick();
      idle();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle();
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // reset state
      chk("rst_full_cnt", DW'(bus.full_cnt), 0);
      chk("rst_wr_ready", DW'(bus.wr_ready), 1);
      chk("rst_rd_avail", DW'(bus.rd_avail), 0);
      chk("rst_rd_valid", DW'(bus.rd_valid), 0);
      chk("rst_rd_data",  bus.rd_data,       0);
      chk("rst_err",      DW'(bus.err),      0);

      // fill bank0 with addr*3, done on the last word
      for (int a = 0; a < DEPTH; a++) wr_word(a, a * 3, a == DEPTH - 1);
      chk("fill0_full_cnt", DW'(bus.full_cnt), 1);
      chk("fill0_rd_avail", DW'(bus.rd_avail), 1);
      chk("fill0_wr_ready", DW'(bus.wr_ready), 1);
      chk("fill0_err",      DW'(bus.err),      0);

      // single read, one-cycle latency, then data holds
      rd_word(5, 1'b0);
      chk("rd5_valid", DW'(bus.rd_valid), 1);
      chk("rd5_data",  bus.rd_data,       15);
      tick();
      chk("rd5_valid_drop", DW'(bus.rd_valid), 0);
      chk("rd5_data_hold",  bus.rd_data,       15);

      // last read together with rd_done
      rd_word(23, 1'b1);
      chk("rd23_valid",    DW'(bus.rd_valid), 1);
      chk("rd23_data",     bus.rd_data,       69);
      chk("rd23_rd_avail", DW'(bus.rd_avail), 0);
      chk("rd23_full_cnt", DW'(bus.full_cnt), 0);

      // fill bank1 then bank0 without reading
      for (int a = 0; a < DEPTH; a++) wr_word(a, 100 + a, a == DEPTH - 1);
      for (int a = 0; a < DEPTH; a++) wr_word(a, 200 + a, a == DEPTH - 1);
      chk("both_full_cnt", DW'(bus.full_cnt), 2);
      chk("both_wr_ready", DW'(bus.wr_ready), 0);
      chk("both_err",      DW'(bus.err),      0);
      wr_word(2, 999, 1'b0);
      chk("ovr_err",      DW'(bus.err),      1);
      chk("ovr_full_cnt", DW'(bus.full_cnt), 2);

      // drain bank1 first, then bank0 still holds its original word
      rd_word(2, 1'b1);
      chk("b1_rd2_data", bus.rd_data, 102);
      chk("b1_full_cnt", DW'(bus.full_cnt), 1);
      chk("b1_wr_ready", DW'(bus.wr_ready), 1);
      rd_word(2, 1'b0);
      chk("b0_rd2_data", bus.rd_data, 202);

      // simultaneous wr_done (bank1) and rd_done (bank0)
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(0);
      bus.wr_data = DW'(7);
      bus.wr_done = 1'b1;
      bus.rd_done = 1'b1;
      tick();
      idle();
      chk("sim_full_cnt", DW'(bus.full_cnt), 1);
      chk("sim_wr_ready", DW'(bus.wr_ready), 1);
      chk("sim_rd_avail", DW'(bus.rd_avail), 1);
      chk("sim_wbank",    DW'(dut.wbank),    0);
      chk("sim_rbank",    DW'(dut.rbank),    1);
      rd_word(0, 1'b1);
      chk("sim_rd0_data",  bus.rd_data,       7);
      chk("sim_rd_avail0", DW'(bus.rd_avail), 0);

      // read with no FULL bank: ignored, data holds
      rd_word(3, 1'b0);
      chk("noav_rd_valid", DW'(bus.rd_valid), 0);
      chk("noav_rd_data",  bus.rd_data,       7);

      // async reset while a read is in flight
      wr_word(0, 11, 1'b1);
      bus.rd_en   = 1'b1;
      bus.rd_addr = AW'(0);
      tick();
      chk("pre_rst_valid", DW'(bus.rd_valid), 1);
      chk("pre_rst_data",  bus.rd_data,       11);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_rd_valid", DW'(bus.rd_valid), 0);
      chk("arst_rd_data",  bus.rd_data,       0);
      chk("arst_full_cnt", DW'(bus.full_cnt), 0);
      chk("arst_wr_ready", DW'(bus.wr_ready), 1);
      chk("arst_rd_avail", DW'(bus.rd_avail), 0);
      chk("arst_err",      DW'(bus.err),      0);
      idle();
      tick();
      rst = 1'b0;
      tick();

      // out-of-range write address
      wr_word(30, 55, 1'b0);
      chk("oor_err",      DW'(bus.err),      1);
      chk("oor_full_cnt", DW'(bus.full_cnt), 0);
      chk("oor_wr_ready", DW'(bus.wr_ready), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
